mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the 32x8 training memory
//  (addr, data_in, data_out, read, write). Converts each requester's req/we handshake
//  into correctly timed single-cycle mem_read/mem_write strobes and returns read data.
//  It is the only master of the memory port; testbench or DUT-side masters attach as m0/m1.
// PARAMETERS
//  ADDR_W  5  memory address width (32 locations)
//  DATA_W  8  memory data width
//  RD_LAT  1  memory read latency in clocks from the mem_read cycle to valid mem_data_out (>=1)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  m0_req        in   1       requester 0 access request; held until m0_gnt
//  m0_we         in   1       1=write, 0=read; stable while m0_req
//  m0_addr       in   ADDR_W  access address; stable while m0_req
//  m0_wdata      in   DATA_W  write data; stable while m0_req
//  m0_gnt        out  1       one-cycle pulse: request accepted, memory strobe this cycle
//  m0_rvalid     out  1       one-cycle pulse: m0_rdata holds read result
//  m0_rdata      out  DATA_W  read data; updated only on m0 reads
//  m1_*          --   --      identical set for requester 1
//  mem_addr      out  ADDR_W  memory address
//  mem_data_in   out  DATA_W  memory write data
//  mem_read      out  1       memory read strobe
//  mem_write     out  1       memory write strobe
//  mem_data_out  in   DATA_W  memory read data
//  busy          out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, any time, incl. mid-access): state=IDLE; all outputs 0; rdata regs 0;
//   last_grant=1 so m0 wins the first contention. Aborted access produces no gnt/rvalid.
//  FSM IDLE -> ACCESS -> (write) IDLE | (read) WAIT -> IDLE. All outputs registered.
//  IDLE: sample m0_req/m1_req. None: stay. One: select it. Both: select !last_grant.
//   On selection latch we/addr/wdata/id, set last_grant=id, go ACCESS.
//   A req dropped before selection is ignored.
//  ACCESS (exactly 1 cycle): mem_addr=latched addr; mem_write=we, mem_read=!we;
//   mem_data_in=wdata on writes, 0 on reads; mX_gnt=1 for winner only.
//   Requester may drop or change req from the cycle after gnt. Write -> IDLE; read -> WAIT.
//  WAIT: counter runs RD_LAT cycles, strobes 0, mem_addr held. On the edge ending the last
//   WAIT cycle, mX_rdata<=mem_data_out and mX_rvalid<=1 (high for the following IDLE cycle);
//   other requester's rdata unchanged. -> IDLE.
//  Latency: write gnt 1 cycle after req seen in IDLE; read rvalid RD_LAT+1 cycles after gnt.
//  Occupancy: write 2 cycles, read 2+RD_LAT cycles; no pipelining, one access outstanding.
//  Sustained dual requests alternate strictly m0,m1,m0,...; a lone requester is served
//   back-to-back. Neither can starve.
//  Never mem_read and mem_write together; gnt never to both; at most one strobe per access.
//  Addresses used as-is (ADDR_W bits, 0..31); no wrap logic needed, 31 is a normal address.
//  When not in ACCESS/WAIT: mem_addr, mem_data_in, mem_read, mem_write = 0.
// TESTING
//  1 rst_n=0 with reqs active -> all outputs 0, busy=0; release -> normal operation.
//  2 m0 write addr 5 = 8'hA5, then m0 read addr 5 -> one gnt + one mem_write, later
//    m0_rvalid with m0_rdata=8'hA5 exactly RD_LAT+1 cycles after read gnt; m1 outputs 0.
//  3 m0 write addr 3 = 8'h11 and m1 read addr 3 raised same cycle after reset -> m0 granted
//    first, m1 next, m1_rdata=8'h11.
//  4 both req held continuously for 8 accesses -> gnt order m0,m1,m0,m1,...; no overlap.
//  5 m1 writes 0 to addrs 0..31 then reads all -> 32 rvalids, all 8'h00; then data=addr,
//    readback of addr 31 = 8'h1F.
//  6 rst_n pulsed low during WAIT of an m0 read -> no m0_rvalid, outputs 0; a following m1
//    write 7 = 8'h3C completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Each accepted request becomes one registered read or write strobe, and read
// data is returned to the requester that issued it after the memory latency.
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    // Counter only has to hold RD_LAT-1 (it counts down to zero).
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic              last_grant, nxt_last;
    logic              cur_we, nxt_we;
    logic              cur_id, nxt_id;

    logic              nxt_m0_gnt, nxt_m1_gnt;
    logic              nxt_m0_rvalid, nxt_m1_rvalid;
    logic [DATA_W-1:0] nxt_m0_rdata, nxt_m1_rdata;
    logic [ADDR_W-1:0] nxt_mem_addr;
    logic [DATA_W-1:0] nxt_mem_data_in;
    logic              nxt_mem_read, nxt_mem_write;
    logic              nxt_busy;

    // Winner selection: a lone requester wins, contention goes to the one not served last.
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_id    = (m0_req & m1_req) ? ~last_grant : m1_req;
    assign sel_we    = sel_id ? m1_we    : m0_we;
    assign sel_addr  = sel_id ? m1_addr  : m0_addr;
    assign sel_wdata = sel_id ? m1_wdata : m0_wdata;

    // State, latched request fields and every output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            cur_we      <= 1'b0;
            cur_id      <= 1'b0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            last_grant  <= nxt_last;
            cur_we      <= nxt_we;
            cur_id      <= nxt_id;
            m0_gnt      <= nxt_m0_gnt;
            m1_gnt      <= nxt_m1_gnt;
            m0_rvalid   <= nxt_m0_rvalid;
            m1_rvalid   <= nxt_m1_rvalid;
            m0_rdata    <= nxt_m0_rdata;
            m1_rdata    <= nxt_m1_rdata;
            mem_addr    <= nxt_mem_addr;
            mem_data_in <= nxt_mem_data_in;
            mem_read    <= nxt_mem_read;
            mem_write   <= nxt_mem_write;
            busy        <= nxt_busy;
        end
    end

    // Next-state and next-output logic; outputs idle at zero unless an access drives them.
    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        nxt_last        = last_grant;
        nxt_we          = cur_we;
        nxt_id          = cur_id;
        nxt_m0_gnt      = 1'b0;
        nxt_m1_gnt      = 1'b0;
        nxt_m0_rvalid   = 1'b0;
        nxt_m1_rvalid   = 1'b0;
        nxt_m0_rdata    = m0_rdata;
        nxt_m1_rdata    = m1_rdata;
        nxt_mem_addr    = '0;
        nxt_mem_data_in = '0;
        nxt_mem_read    = 1'b0;
        nxt_mem_write   = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    nxt_state       = ACCESS;
                    nxt_id          = sel_id;
                    nxt_we          = sel_we;
                    nxt_last        = sel_id;
                    nxt_m0_gnt      = ~sel_id;
                    nxt_m1_gnt      = sel_id;
                    nxt_mem_addr    = sel_addr;
                    nxt_mem_data_in = sel_we ? sel_wdata : '0;
                    nxt_mem_write   = sel_we;
                    nxt_mem_read    = ~sel_we;
                end
            end
            ACCESS: begin
                if (cur_we) begin
                    nxt_state = IDLE;
                end else begin
                    // Keep the address on the bus while the memory produces data.
                    nxt_state    = WAIT;
                    nxt_cnt      = CNT_W'(RD_LAT - 1);
                    nxt_mem_addr = mem_addr;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    nxt_state = IDLE;
                    if (cur_id) begin
                        nxt_m1_rvalid = 1'b1;
                        nxt_m1_rdata  = mem_data_out;
                    end else begin
                        nxt_m0_rvalid = 1'b1;
                        nxt_m0_rdata  = mem_data_out;
                    end
                end else begin
                    nxt_cnt      = cnt - CNT_W'(1);
                    nxt_mem_addr = mem_addr;
                end
            end
            default: nxt_state = IDLE;
        endcase

        nxt_busy = (nxt_state != IDLE);
    end

endmodule
